noc_arbiter2: RTL and testbench
===============================

NOC_ARBITER2 -- requirements
Module: noc_arbiter2

Interface
REQ-001 SHALL have parameter W, default 9, flit width; bits [8:5] carry the destination address and pass through unmodified.
REQ-002 SHALL have parameter BURST, default 4, maximum consecutive grants to one input while the other input waits; legal range 1..15.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port _RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in0_data  input  W  flit from requester 0.
REQ-006 SHALL have port in0_valid  input  1  requester 0 offers a flit.
REQ-007 SHALL have port in0_ready  output  1  flit on in0 accepted this cycle.
REQ-008 SHALL have ports in1_data / in1_valid / in1_ready, identical to in0 for requester 1.
REQ-009 SHALL have port out_data  output  W  registered granted flit.
REQ-010 SHALL have port out_src  output  1  source of out_data (0 = in0, 1 = in1), valid with out_valid.
REQ-011 SHALL have port out_valid  output  1  out_data holds a flit.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the out flit this cycle.

Function
REQ-013 Transfer on any channel SHALL occur on a rising edge with valid=1 and ready=1; valid SHALL never depend combinationally on ready.
REQ-014 Output stage SHALL be a one-entry register; load_en = !out_valid | out_ready.
REQ-015 in0_ready / in1_ready SHALL equal load_en AND (grant == that input) AND that input's valid; at most one SHALL be 1 per cycle.
REQ-016 An accepted flit SHALL appear on out_data / out_src with out_valid=1 on the next cycle (latency 1); sustained throughput SHALL be 1 flit/cycle.
REQ-017 If out_valid=1 and out_ready=0, out_data / out_src SHALL hold, and both in*_ready SHALL be 0.
REQ-018 FSM states SHALL be IDLE, G0, and G1; the registers are prio (1 bit) and cnt (4 bits).
REQ-019 In IDLE, a single valid input SHALL be granted; if both inputs are valid, input prio SHALL be granted.
REQ-020 In Gi, input i SHALL be granted if in_i_valid and (cnt < BURST or the other input is not valid); otherwise the other input SHALL be granted if it is valid.
REQ-021 On a transfer from input i, the FSM SHALL move to Gi.
  - cnt = 1 if the previous state was not Gi.
  - Otherwise cnt = min(cnt+1, BURST).
  - prio = ~i.
REQ-022 In Gi, with load_en=1 and no input valid, the FSM SHALL return to IDLE, with cnt=0 and prio unchanged.
REQ-023 In any state, when load_en=0, state, cnt and prio SHALL hold.
REQ-024 Simultaneous load and drain (out_valid & out_ready & input transfer) SHALL replace the output flit in the same edge with no bubble.
REQ-025 The block SHALL not reorder flits from one input and SHALL not drop or duplicate flits.

Reset
REQ-026 While _RESET=0, the following outputs SHALL be 0: out_valid, out_data, out_src, in0_ready, in1_ready.
REQ-027 While _RESET=0, the internal state SHALL be: state=IDLE, cnt=0, prio=0.
REQ-028 Reset asserted mid-operation SHALL discard the held output flit; after release, the first grant SHALL follow REQ-019 with prio=0.

Verification
REQ-029 Single input: in0 sends 0x1A5, 0x0F3 back-to-back, out_ready=1 -> out_valid on cycles 1 and 2 with data 0x1A5, 0x0F3 and out_src=0; in1_ready stays 0.
REQ-030 Contention from reset: both inputs valid continuously, BURST=4, out_ready=1.
  - Grant sequence SHALL be in0 ×4, in1 ×4, in0 ×4, ...
  - out_src SHALL follow 0000 1111 0000.
REQ-031 Backpressure: out_ready=0 for 3 cycles while out_valid=1 and both inputs valid -> out_data held, both in*_ready=0; upon out_ready=1 the next flit loads on the same edge.
REQ-032 Burst release: in0 streams; in1 asserts valid at cycle 10 with cnt=BURST -> in1 is granted on the next load cycle; if in1 drops after 1 flit, in0 resumes with cnt=1.
REQ-033 Idle/priority: in1 sends 1 flit, then both idle, then both valid in the same cycle -> in0 is granted (prio=0 after the in1 transfer).
REQ-034 Reset mid-stream: assert _RESET with out_valid=1 -> out_valid=0 immediately; after release, both inputs valid -> first grant is in0 and no stale flit appears.

Source files
------------

// File: rtl/noc_arbiter2.sv
// noc_arbiter2: two-input flit arbiter with burst-limited round-robin and a one-entry output register
module noc_arbiter2 #(
    parameter int W     = 9,
    parameter int BURST = 4
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_src,
    output logic         out_valid,
    input  logic         out_ready
);
    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

    state_t       r_state, w_state_nx;
    logic         r_prio, w_prio_nx;
    logic [3:0]   r_cnt, w_cnt_nx;
    logic [W-1:0] r_data;
    logic         r_src, r_valid;
    logic         w_load, w_gnt, w_xfer, w_cur, w_v_cur, w_v_oth;

    assign w_load    = !r_valid | out_ready;
    assign in0_ready = _RESET & w_load & !w_gnt & in0_valid;
    assign in1_ready = _RESET & w_load &  w_gnt & in1_valid;
    assign w_xfer    = in0_ready | in1_ready;
    assign out_data  = r_data;
    assign out_src   = r_src;
    assign out_valid = r_valid;

    // Grant: IDLE resolves ties by prio; a Gi state keeps i until its burst is used up and the other input waits
    always_comb begin
        w_cur   = (r_state == G1);
        w_v_cur = w_cur ? in1_valid : in0_valid;
        w_v_oth = w_cur ? in0_valid : in1_valid;
        w_gnt   = (r_state == IDLE) ? ((in0_valid & in1_valid) ? r_prio : in1_valid)
                : (w_v_cur && (r_cnt < 4'(BURST) || !w_v_oth)) ? w_cur
                : (w_v_oth ? !w_cur : w_cur);
    end

    // Next state: a transfer moves to the granted input's state; a load slot with nothing offered returns to IDLE
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_prio_nx  = r_prio;
        if (w_xfer) begin
            w_state_nx = w_gnt ? G1 : G0;
            w_cnt_nx   = (r_state != (w_gnt ? G1 : G0)) ? 4'd1
                       : (r_cnt >= 4'(BURST)) ? 4'(BURST) : r_cnt + 4'd1;
            w_prio_nx  = !w_gnt;
        end else if (w_load && r_state != IDLE) begin
            w_state_nx = IDLE;
            w_cnt_nx   = 4'd0;
        end
    end

    // Arbitration state register
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_prio  <= w_prio_nx;
        end
    end

    // Output register: reloads whenever it is empty or being drained, so load and drain share one edge
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_data  <= '0;
            r_src   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_gnt ? in1_data : in0_data;
                r_src  <= w_gnt;
            end
        end
    end
endmodule

// File: tb/tb_noc_arbiter2.sv
// tb_noc_arbiter2: directed vectors with hand-computed expectations for noc_arbiter2
module tb_noc_arbiter2;
    logic       CLK = 1'b0;
    logic       _RESET;
    logic [8:0] in0_data, in1_data, out_data;
    logic       in0_valid, in1_valid, in0_ready, in1_ready;
    logic       out_src, out_valid, out_ready;
    int         n_cmp = 0;
    int         n_err = 0;
    int         c0, c1;
    logic       e;
    logic [8:0] exp_d;

    noc_arbiter2 #(.W(9), .BURST(4)) dut (
        .CLK(CLK), ._RESET(_RESET),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        _RESET = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        _RESET = 1'b1;
    endtask

    initial begin
        _RESET = 1'b0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data = 9'h1A5;
        in1_data = 9'h0AA;
        out_ready = 1'b1;
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_src", 32'(out_src), 0);
        chk("rst_rdy0", 32'(in0_ready), 0);
        chk("rst_rdy1", 32'(in1_ready), 0);
        tick;
        tick;
        // single input back-to-back
        _RESET = 1'b1;
        in1_valid = 1'b0;
        #1;
        chk("s_rdy0_a", 32'(in0_ready), 1);
        chk("s_rdy1_a", 32'(in1_ready), 0);
        tick;
        chk("s_valid_a", 32'(out_valid), 1);
        chk("s_data_a", 32'(out_data), 32'h1A5);
        chk("s_src_a", 32'(out_src), 0);
        in0_data = 9'h0F3;
        #1;
        chk("s_rdy1_b", 32'(in1_ready), 0);
        tick;
        chk("s_data_b", 32'(out_data), 32'h0F3);
        chk("s_src_b", 32'(out_src), 0);
        in0_valid = 1'b0;
        tick;
        chk("s_drain", 32'(out_valid), 0);
        // contention from reset: 0000 1111 0000
        do_reset;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 12; k++) begin
            e = ((k / 4) % 2) == 1;
            in0_data = {4'hA, 5'(c0)};
            in1_data = {4'h5, 5'(c1)};
            exp_d = e ? in1_data : in0_data;
            #1;
            chk("c_rdy0", 32'(in0_ready), 32'(!e));
            chk("c_rdy1", 32'(in1_ready), 32'(e));
            tick;
            chk("c_src", 32'(out_src), 32'(e));
            chk("c_data", 32'(out_data), 32'(exp_d));
            if (e) c1++; else c0++;
        end
        // backpressure: hold three cycles, then load on the release edge
        exp_d = {4'hA, 5'(c0 - 1)};
        in0_data = {4'hA, 5'(c0)};
        in1_data = {4'h5, 5'(c1)};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_rdy0", 32'(in0_ready), 0);
            chk("bp_rdy1", 32'(in1_ready), 0);
            tick;
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'(exp_d));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy1", 32'(in1_ready), 1);
        chk("bp_rel_rdy0", 32'(in0_ready), 0);
        tick;
        chk("bp_rel_src", 32'(out_src), 1);
        chk("bp_rel_data", 32'(out_data), 32'({4'h5, 5'(c1)}));
        // burst release
        do_reset;
        in0_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in0_data = {4'hA, 5'(k)};
            #1;
            chk("br_rdy0", 32'(in0_ready), 1);
            tick;
            chk("br_data", 32'(out_data), 32'({4'hA, 5'(k)}));
        end
        in1_valid = 1'b1;
        in1_data = 9'h1C3;
        #1;
        chk("br_sw_rdy1", 32'(in1_ready), 1);
        chk("br_sw_rdy0", 32'(in0_ready), 0);
        tick;
        chk("br_sw_src", 32'(out_src), 1);
        chk("br_sw_data", 32'(out_data), 32'h1C3);
        in1_valid = 1'b0;
        in0_data = 9'h14A;
        #1;
        chk("br_res_rdy0", 32'(in0_ready), 1);
        tick;
        chk("br_res_src", 32'(out_src), 0);
        chk("br_res_data", 32'(out_data), 32'h14A);
        in1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("br_cnt_rdy0", 32'(in0_ready), 1);
            tick;
        end
        #1;
        chk("br_cnt_rdy1", 32'(in1_ready), 1);
        tick;
        // idle / priority
        do_reset;
        in1_valid = 1'b1;
        in1_data = 9'h0E1;
        #1;
        chk("ip_rdy1", 32'(in1_ready), 1);
        tick;
        chk("ip_src", 32'(out_src), 1);
        in1_valid = 1'b0;
        tick;
        tick;
        chk("ip_idle", 32'(out_valid), 0);
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        #1;
        chk("ip_both_rdy0", 32'(in0_ready), 1);
        chk("ip_both_rdy1", 32'(in1_ready), 0);
        tick;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick;
        tick;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        #1;
        chk("ip_flip_rdy1", 32'(in1_ready), 1);
        chk("ip_flip_rdy0", 32'(in0_ready), 0);
        tick;
        chk("ip_flip_valid", 32'(out_valid), 1);
        // reset mid-stream
        _RESET = 1'b0;
        #1;
        chk("rm_valid", 32'(out_valid), 0);
        chk("rm_rdy0", 32'(in0_ready), 0);
        tick;
        _RESET = 1'b1;
        in0_data = 9'h055;
        #1;
        chk("rm_rel_valid", 32'(out_valid), 0);
        chk("rm_rel_rdy0", 32'(in0_ready), 1);
        chk("rm_rel_rdy1", 32'(in1_ready), 0);
        tick;
        chk("rm_src", 32'(out_src), 0);
        chk("rm_data", 32'(out_data), 32'h055);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
